mmu_ptw_ctrl: RTL and testbench
===============================

Name: mmu_ptw_ctrl

Overview:
Sv32 hardware page-table walker shared by the instruction TLB (port 0) and data TLB (port 1). Arbitrates miss requests round-robin, performs the two-level walk over a single-outstanding memory read port, checks the PTE, and returns an mmu_response_t plus a tlb_entry_t refill. Sits between the I/D TLBs and the L1D/memory arbiter.

Parameters:
NUM_REQ, 2, number of requesters (fixed at 2; 0=ITLB, 1=DTLB)
PTE_WIDTH, 32, Sv32 PTE width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
satp_mode_i  in  1  0=bare, 1=Sv32
satp_ppn_i  in  20  root page-table PPN
flush_i  in  1  sfence.vma pulse
req_valid_i  in  2  miss request per port
req_ready_o  out  2  grant/accept per port
req_i  in  2 x mmu_request_t  vaddr/is_write/is_fetch per port
rsp_valid_o  out  1  one-cycle response pulse
rsp_id_o  out  1  port the response belongs to
rsp_o  out  mmu_response_t  paddr/hit/fault/fault_type
rsp_entry_o  out  tlb_entry_t  refill entry, valid with rsp_valid_o
mem_req_valid_o  out  1  PTE read request
mem_req_ready_i  in  1  memory accepts request
mem_addr_o  out  32  PTE address
mem_rsp_valid_i  in  1  read data valid
mem_rdata_i  in  32  PTE data
mem_err_i  in  1  bus error, qualified by mem_rsp_valid_i

Behaviour:
- Reset: state IDLE, all outputs 0, round-robin priority to port 0, stale flag 0.
- States: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DONE.
- IDLE: if any req_valid_i, winner = round-robin (last-granted port loses ties); req_ready_o[winner]=1 that cycle only; latch request and id. Bare mode -> DONE; else -> L1_REQ. req_ready_o is 0 in every other state.
- L1_REQ: mem_req_valid_o=1, mem_addr_o={satp_ppn_i, vpn[19:10], 2'b00}; hold until mem_req_ready_i, then L1_WAIT. Address/valid stable while stalled.
- L1_WAIT: on mem_rsp_valid_i: mem_err_i -> fault 4; V=0 or (W=1,R=0) -> fault 1; leaf (R|X) with PPN[9:0]!=0 -> fault 2; leaf -> permission check -> DONE; non-leaf -> L0_REQ with next base = PTE[29:10].
- L0_REQ: addr={pte_ppn[19:0], vpn[9:0], 2'b00}; handshake as L1_REQ.
- L0_WAIT: same checks as L1_WAIT; non-leaf -> fault 3.
- Permission check (leaf): fetch && !X, write && !W, read && !R, A=0, or write && D=0 -> fault 5. No hardware A/D update.
- PTE[31:30] != 0 on any consumed PTE -> fault 4 (PA beyond 32 bits).
- DONE: rsp_valid_o=1 for exactly one cycle, then IDLE. Next grant earliest the cycle after DONE.
- Success: hit=1, fault=0, fault_type=0. paddr={ppn, vaddr[11:0]}. Superpage ppn={PTE.PPN1[9:0], vpn[9:0]}. Bare: paddr=vaddr, entry.ppn=vpn, all perms 1.
- Fault: hit=0, fault=1, paddr=0, entry.valid=0.
- Entry: vpn, ppn, valid, D/A/G/U/R/W/X copied from leaf, rsvd[0]=superpage, rsvd[1]=0.
- Latency (no stalls, 1-cycle memory): grant N, L1 req N+1, L0 req N+3, rsp N+5; superpage N+3; bare N+1.
- mem_rsp_valid_i outside *_WAIT is ignored. Memory responses arrive in order, one outstanding.
- flush_i while not IDLE sets stale. The walk still completes its outstanding read, but skips remaining levels and goes to DONE with hit=0, fault=0 (retry; requester must not install and must reissue). Stale clears in DONE. flush_i in IDLE has no effect.
- Simultaneous flush_i with final mem_rsp: stale wins.
- Mid-walk reset returns to IDLE; any later mem_rsp_valid_i is ignored.
- Requesters must hold req_i stable while req_valid_i=1 and ready=0.

Decomposition:
- mmu_pkg additions: ptw_state_e; fault-type localparams (NONE=0, INVALID=1, MISALIGNED=2, NOLEAF=3, ACCESS=4, PERM=5); PTE bit-position localparams (V0 R1 W2 X3 U4 G5 A6 D7, PPN 31:10); SV32_VPN_LVL_WIDTH=10.
- Sub-module: mmu_rr_arbiter (2-way round-robin with priority register update on grant).

Test Plan:
- satp_ppn=0x80000, port1 read vaddr 0x00401234; mem[0x80000004]=0x20000401, mem[0x80001004]=0x048D14D7 -> addrs 0x80000004 then 0x80001004; rsp paddr 0x12345234, hit=1, id=1, entry.ppn=0x12345.
- Same vaddr, mem[0x80000004]=0x049000CF -> single read; paddr 0x12401234, entry.rsvd[0]=1. With 0x049004CF -> fault_type 2.
- Both ports valid in IDLE after reset -> port 0 granted first, then port 1; with both held continuously, grants alternate 0,1,0,1.
- Port1 write, leaf 0x048D1457 (D=0) -> fault 5. Port0 fetch on X=0 leaf -> fault 5. L0 PTE 0x20000401 -> fault 3. mem_err_i on L1 -> fault 4.
- flush_i during L1_WAIT with non-leaf L1 PTE -> no L0 read; rsp hit=0, fault=0.
- satp_mode_i=0, vaddr 0xDEADB000 -> no mem_req_valid_o; rsp one cycle after grant, paddr 0xDEADB000, hit=1.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared MMU types and constants: requests/responses, TLB refill entries,
// walker state encodings, Sv32 PTE field positions and fault codes.
package mmu_pkg;

    localparam int SV32_VPN_LVL_WIDTH = 10;

    typedef logic [2:0] ptw_state_e;
    localparam ptw_state_e PTW_IDLE    = 3'd0;
    localparam ptw_state_e PTW_L1_REQ  = 3'd1;
    localparam ptw_state_e PTW_L1_WAIT = 3'd2;
    localparam ptw_state_e PTW_L0_REQ  = 3'd3;
    localparam ptw_state_e PTW_L0_WAIT = 3'd4;
    localparam ptw_state_e PTW_DONE    = 3'd5;

    localparam logic [2:0] FAULT_NONE       = 3'd0;
    localparam logic [2:0] FAULT_INVALID    = 3'd1;
    localparam logic [2:0] FAULT_MISALIGNED = 3'd2;
    localparam logic [2:0] FAULT_NOLEAF     = 3'd3;
    localparam logic [2:0] FAULT_ACCESS     = 3'd4;
    localparam logic [2:0] FAULT_PERM       = 3'd5;

    localparam int PTE_V       = 0;
    localparam int PTE_R       = 1;
    localparam int PTE_W       = 2;
    localparam int PTE_X       = 3;
    localparam int PTE_U       = 4;
    localparam int PTE_G       = 5;
    localparam int PTE_A       = 6;
    localparam int PTE_D       = 7;
    localparam int PTE_PPN_LSB = 10;
    localparam int PTE_PPN_MSB = 31;

    typedef struct packed {
        logic [31:0] vaddr;
        logic        is_write;
        logic        is_fetch;
    } mmu_request_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic        hit;
        logic        fault;
        logic [2:0]  fault_type;
    } mmu_response_t;

    typedef struct packed {
        logic [19:0] vpn;
        logic [19:0] ppn;
        logic        valid;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        r;
        logic        w;
        logic        x;
        logic [1:0]  rsvd;
    } tlb_entry_t;

endpackage

// File: rtl/mmu_rr_arbiter.sv
// Two-way round-robin arbiter; the port granted last loses the next tie.
module mmu_rr_arbiter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] grant_o,
    output logic       grant_id_o
);

    logic prio_q;  // port that wins when both request

    always_comb begin
        grant_id_o = (req_i[0] && req_i[1]) ? prio_q : req_i[1];
        grant_o    = 2'b00;
        if (en_i && (|req_i)) begin
            grant_o = grant_id_o ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else if (en_i && (|req_i)) begin
            prio_q <= ~grant_id_o;
        end
    end

endmodule

// File: rtl/mmu_ptw_ctrl.sv
// Sv32 page-table walker shared by ITLB (port 0) and DTLB (port 1): arbitrates
// misses, walks two levels over a single-outstanding read port, returns a refill.
module mmu_ptw_ctrl
    import mmu_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int PTE_WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         satp_mode_i,
    input  logic [19:0]                  satp_ppn_i,
    input  logic                         flush_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  mmu_request_t [NUM_REQ-1:0]   req_i,
    output logic                         rsp_valid_o,
    output logic                         rsp_id_o,
    output mmu_response_t                rsp_o,
    output tlb_entry_t                   rsp_entry_o,
    output logic                         mem_req_valid_o,
    input  logic                         mem_req_ready_i,
    output logic [31:0]                  mem_addr_o,
    input  logic                         mem_rsp_valid_i,
    input  logic [PTE_WIDTH-1:0]         mem_rdata_i,
    input  logic                         mem_err_i
);

    ptw_state_e    state;
    logic          cur_id;
    mmu_request_t  cur_req;
    logic [19:0]   base_ppn;
    logic          stale;
    mmu_response_t rsp_q;
    tlb_entry_t    entry_q;

    logic [1:0]    grant;
    logic          grant_id;
    mmu_request_t  sel_req;

    logic          lvl1;
    logic [2:0]    chk_ft;
    logic          pte_leaf;
    tlb_entry_t    leaf_entry;
    mmu_response_t leaf_rsp;

    function automatic logic [2:0] pte_fault(input logic [PTE_WIDTH-1:0] pte,
                                             input logic lvl1_f,
                                             input mmu_request_t rq);
        logic leaf;
        logic is_read;
        leaf    = pte[PTE_R] | pte[PTE_X];
        is_read = !rq.is_fetch && !rq.is_write;
        if (!pte[PTE_V] || (pte[PTE_W] && !pte[PTE_R])) return FAULT_INVALID;
        if (pte[PTE_PPN_MSB -: 2] != 2'b00)              return FAULT_ACCESS;
        if (!leaf)                                      return lvl1_f ? FAULT_NONE : FAULT_NOLEAF;
        if (lvl1_f && pte[PTE_PPN_LSB +: SV32_VPN_LVL_WIDTH] != '0) return FAULT_MISALIGNED;
        if ((rq.is_fetch && !pte[PTE_X]) || (rq.is_write && !pte[PTE_W]) ||
            (is_read && !pte[PTE_R]) || !pte[PTE_A] || (rq.is_write && !pte[PTE_D]))
            return FAULT_PERM;
        return FAULT_NONE;
    endfunction

    function automatic mmu_response_t fault_rsp(input logic [2:0] ft);
        mmu_response_t r;
        r            = '0;
        r.fault      = 1'b1;
        r.fault_type = ft;
        return r;
    endfunction

    mmu_rr_arbiter u_arb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (state == PTW_IDLE),
        .req_i      (req_valid_i),
        .grant_o    (grant),
        .grant_id_o (grant_id)
    );

    assign sel_req         = req_i[grant_id];
    assign req_ready_o     = grant;
    assign mem_req_valid_o = (state == PTW_L1_REQ) || (state == PTW_L0_REQ);
    assign rsp_valid_o     = (state == PTW_DONE);
    assign rsp_id_o        = (state == PTW_DONE) && cur_id;
    assign rsp_o           = rsp_q;
    assign rsp_entry_o     = entry_q;
    assign lvl1            = (state == PTW_L1_WAIT);

    always_comb begin
        mem_addr_o = '0;
        if (state == PTW_L1_REQ) begin
            mem_addr_o = {satp_ppn_i, cur_req.vaddr[31:22], 2'b00};
        end else if (state == PTW_L0_REQ) begin
            mem_addr_o = {base_ppn, cur_req.vaddr[21:12], 2'b00};
        end
    end

    // Leaf decode of the PTE on the read-data bus; a level-1 leaf is a 4 MiB superpage.
    always_comb begin
        chk_ft           = pte_fault(mem_rdata_i, lvl1, cur_req);
        pte_leaf         = mem_rdata_i[PTE_R] | mem_rdata_i[PTE_X];
        leaf_entry       = '0;
        leaf_entry.vpn   = cur_req.vaddr[31:12];
        leaf_entry.ppn   = lvl1 ? {mem_rdata_i[29:20], cur_req.vaddr[21:12]} : mem_rdata_i[29:10];
        leaf_entry.valid = 1'b1;
        leaf_entry.d     = mem_rdata_i[PTE_D];
        leaf_entry.a     = mem_rdata_i[PTE_A];
        leaf_entry.g     = mem_rdata_i[PTE_G];
        leaf_entry.u     = mem_rdata_i[PTE_U];
        leaf_entry.r     = mem_rdata_i[PTE_R];
        leaf_entry.w     = mem_rdata_i[PTE_W];
        leaf_entry.x     = mem_rdata_i[PTE_X];
        leaf_entry.rsvd  = {1'b0, lvl1};
        leaf_rsp         = '0;
        leaf_rsp.paddr   = {leaf_entry.ppn, cur_req.vaddr[11:0]};
        leaf_rsp.hit     = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= PTW_IDLE;
            cur_id   <= 1'b0;
            cur_req  <= '0;
            base_ppn <= '0;
            stale    <= 1'b0;
            rsp_q    <= '0;
            entry_q  <= '0;
        end else begin
            if (flush_i && state != PTW_IDLE) begin
                stale <= 1'b1;
            end
            case (state)
                PTW_IDLE: begin
                    if (|grant) begin
                        cur_id  <= grant_id;
                        cur_req <= sel_req;
                        if (!satp_mode_i) begin
                            state         <= PTW_DONE;
                            rsp_q         <= '0;
                            rsp_q.paddr   <= sel_req.vaddr;
                            rsp_q.hit     <= 1'b1;
                            entry_q       <= '1;
                            entry_q.vpn   <= sel_req.vaddr[31:12];
                            entry_q.ppn   <= sel_req.vaddr[31:12];
                            entry_q.rsvd  <= 2'b00;
                        end else begin
                            state <= PTW_L1_REQ;
                        end
                    end
                end
                PTW_L1_REQ: if (mem_req_ready_i) state <= PTW_L1_WAIT;
                PTW_L0_REQ: if (mem_req_ready_i) state <= PTW_L0_WAIT;
                PTW_L1_WAIT, PTW_L0_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        // A flush seen at any point during the walk turns the result into a retry.
                        if (stale || flush_i) begin
                            state   <= PTW_DONE;
                            rsp_q   <= '0;
                            entry_q <= '0;
                        end else if (mem_err_i) begin
                            state   <= PTW_DONE;
                            rsp_q   <= fault_rsp(FAULT_ACCESS);
                            entry_q <= '0;
                        end else if (chk_ft != FAULT_NONE) begin
                            state   <= PTW_DONE;
                            rsp_q   <= fault_rsp(chk_ft);
                            entry_q <= '0;
                        end else if (!pte_leaf) begin
                            state    <= PTW_L0_REQ;
                            base_ppn <= mem_rdata_i[29:10];
                        end else begin
                            state   <= PTW_DONE;
                            rsp_q   <= leaf_rsp;
                            entry_q <= leaf_entry;
                        end
                    end
                end
                PTW_DONE: begin
                    state <= PTW_IDLE;
                    stale <= 1'b0;
                end
                default: state <= PTW_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_ptw_ctrl.sv
// Directed scoreboard bench for mmu_ptw_ctrl with a scripted single-outstanding memory.
module tb_mmu_ptw_ctrl;
    import mmu_pkg::*;

    logic               clk = 1'b0;
    logic               rst_i;
    logic               satp_mode_i;
    logic [19:0]        satp_ppn_i;
    logic               flush_i;
    logic [1:0]         req_valid_i;
    logic [1:0]         req_ready_o;
    mmu_request_t [1:0] req_i;
    logic               rsp_valid_o;
    logic               rsp_id_o;
    mmu_response_t      rsp_o;
    tlb_entry_t         rsp_entry_o;
    logic               mem_req_valid_o;
    logic               mem_req_ready_i;
    logic [31:0]        mem_addr_o;
    logic               mem_rsp_valid_i;
    logic [31:0]        mem_rdata_i;
    logic               mem_err_i;

    mmu_ptw_ctrl #(.NUM_REQ(2), .PTE_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .satp_mode_i(satp_mode_i), .satp_ppn_i(satp_ppn_i),
        .flush_i(flush_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_i(req_i),
        .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_o(rsp_o), .rsp_entry_o(rsp_entry_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_addr_o(mem_addr_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        mmu_response_t rsp;
        tlb_entry_t    ent;
        int            lat;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        logic        flush;
        int          dly;
        int          stall;
    } mem_op_t;

    exp_t    exp_q[$];
    mem_op_t mem_script[$];
    mem_op_t pend;
    logic    pend_active = 1'b0;
    logic    pend_first  = 1'b0;
    int      pend_cnt    = 0;
    int      acc_cnt     = 0;
    int      grant_cnt   = 0;
    int      grant_cyc   = 0;
    int      cyc         = 0;
    int      checks      = 0;
    int      errors      = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    function automatic tlb_entry_t mk_ent(input logic [19:0] vpn, input logic [19:0] ppn,
                                          input logic [6:0] dagurwx, input logic sp);
        tlb_entry_t e;
        e       = '0;
        e.vpn   = vpn;
        e.ppn   = ppn;
        e.valid = 1'b1;
        {e.d, e.a, e.g, e.u, e.r, e.w, e.x} = dagurwx;
        e.rsvd  = {1'b0, sp};
        return e;
    endfunction

    task automatic push_ok(input int id, input logic [31:0] pa, input tlb_entry_t e, input int lat);
        exp_t x;
        x.id = id; x.rsp = '0; x.rsp.paddr = pa; x.rsp.hit = 1'b1; x.ent = e; x.lat = lat;
        exp_q.push_back(x);
    endtask

    task automatic push_fault(input int id, input logic [2:0] ft);
        exp_t x;
        x.id = id; x.rsp = '0; x.rsp.fault = 1'b1; x.rsp.fault_type = ft; x.ent = '0; x.lat = -1;
        exp_q.push_back(x);
    endtask

    task automatic push_retry(input int id);
        exp_t x;
        x.id = id; x.rsp = '0; x.ent = '0; x.lat = -1;
        exp_q.push_back(x);
    endtask

    task automatic mem_op(input logic [31:0] a, input logic [31:0] d, input logic err,
                          input logic fl, input int dly, input int stall);
        mem_op_t m;
        m.addr = a; m.data = d; m.err = err; m.flush = fl; m.dly = dly; m.stall = stall;
        mem_script.push_back(m);
    endtask

    task automatic issue(input int port, input logic [31:0] va, input logic wr, input logic fe);
        int n;
        n = 0;
        @(posedge clk); #1;
        req_i[port]       = '{vaddr: va, is_write: wr, is_fetch: fe};
        req_valid_i[port] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready_o[port] && n < 50);
        if (!req_ready_o[port]) begin
            checks++; errors++;
            $display("FAIL grant_wait port %0d: ready %b after %0d cycles, required 1", port, req_ready_o[port], n);
        end
        @(posedge clk); #1;
        req_valid_i[port] = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s timeout: %0d responses outstanding, required 0", nm, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
        check({nm, "_reads_left"}, 64'(mem_script.size()), 64'd0);
        mem_script.delete();
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard monitor: grants and responses sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_i) begin
            if (|req_ready_o) begin
                grant_cnt++;
                grant_cyc = cyc;
            end
            if (rsp_valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: id %0d rsp %h, required no response", rsp_id_o, rsp_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_id", 64'(rsp_id_o), 64'(e.id));
                    check("rsp", 64'(rsp_o), 64'(e.rsp));
                    check("rsp_entry", 64'(rsp_entry_o), 64'(e.ent));
                    if (e.lat >= 0) check("latency", 64'(cyc - grant_cyc), 64'(e.lat));
                end
            end
        end
    end

    // Scripted memory: address checked on every requesting cycle, data returned after dly cycles
    initial begin
        mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b0; mem_rdata_i = '0;
        mem_err_i = 1'b0; flush_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            mem_rsp_valid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
            flush_i = 1'b0; mem_req_ready_i = 1'b1;
            if (pend_active) begin
                if (pend_first && pend.flush && pend.dly != 0) flush_i = 1'b1;
                pend_first = 1'b0;
                if (pend_cnt == 0) begin
                    mem_rsp_valid_i = 1'b1;
                    mem_rdata_i     = pend.data;
                    mem_err_i       = pend.err;
                    if (pend.flush && pend.dly == 0) flush_i = 1'b1;
                    pend_active = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (mem_req_valid_o) begin
                if (mem_script.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_unexpected: addr %h, required no request", mem_addr_o);
                end else begin
                    check("mem_addr", 64'(mem_addr_o), 64'(mem_script[0].addr));
                    if (mem_script[0].stall > 0) begin
                        mem_req_ready_i = 1'b0;
                        mem_script[0].stall = mem_script[0].stall - 1;
                    end else begin
                        pend        = mem_script.pop_front();
                        pend_active = 1'b1;
                        pend_first  = 1'b1;
                        pend_cnt    = pend.dly;
                        acc_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int a0;
        rst_i = 1'b1; satp_mode_i = 1'b1; satp_ppn_i = 20'h80000;
        req_valid_i = 2'b00; req_i = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready_o), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_rsp_id", 64'(rsp_id_o), 64'd0);
        check("rst_rsp", 64'(rsp_o), 64'd0);
        check("rst_entry", 64'(rsp_entry_o), 64'd0);
        check("rst_mem_valid", 64'(mem_req_valid_o), 64'd0);
        check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk);

        // Two-level walk, 4 KiB page
        mem_op(32'h80000004, 32'h20000401, 1'b0, 1'b0, 0, 0);
        mem_op(32'h80001004, 32'h048D14D7, 1'b0, 1'b0, 0, 0);
        push_ok(1, 32'h12345234, mk_ent(20'h00401, 20'h12345, 7'b1101110, 1'b0), 5);
        issue(1, 32'h00401234, 1'b0, 1'b0);
        wait_done("walk4k");

        // Superpage leaf at level 1
        mem_op(32'h80000004, 32'h049000CF, 1'b0, 1'b0, 0, 0);
        push_ok(0, 32'h12401234, mk_ent(20'h00401, 20'h12401, 7'b1100111, 1'b1), 3);
        issue(0, 32'h00401234, 1'b0, 1'b0);
        wait_done("superpage");

        mem_op(32'h80000004, 32'h049004CF, 1'b0, 1'b0, 0, 0);
        push_fault(1, FAULT_MISALIGNED);
        issue(1, 32'h00401234, 1'b0, 1'b0);
        wait_done("misaligned");

        mem_op(32'h80000004, 32'h20000401, 1'b0, 1'b0, 0, 0);
        mem_op(32'h80001004, 32'h048D1457, 1'b0, 1'b0, 0, 0);
        push_fault(1, FAULT_PERM);
        issue(1, 32'h00401234, 1'b1, 1'b0);
        wait_done("write_dirty0");

        mem_op(32'h80000004, 32'h20000401, 1'b0, 1'b0, 0, 0);
        mem_op(32'h80001004, 32'h048D14D7, 1'b0, 1'b0, 0, 0);
        push_fault(0, FAULT_PERM);
        issue(0, 32'h00401234, 1'b0, 1'b1);
        wait_done("fetch_nox");

        mem_op(32'h80000004, 32'h20000401, 1'b0, 1'b0, 0, 0);
        mem_op(32'h80001004, 32'h20000401, 1'b0, 1'b0, 0, 0);
        push_fault(0, FAULT_NOLEAF);
        issue(0, 32'h00401234, 1'b0, 1'b0);
        wait_done("noleaf");

        mem_op(32'h80000004, 32'h20000401, 1'b1, 1'b0, 0, 0);
        push_fault(1, FAULT_ACCESS);
        issue(1, 32'h00401234, 1'b0, 1'b0);
        wait_done("bus_err");

        mem_op(32'h80000004, 32'hC00000CF, 1'b0, 1'b0, 0, 0);
        push_fault(0, FAULT_ACCESS);
        issue(0, 32'h00401234, 1'b0, 1'b0);
        wait_done("pa_over32");

        // Flush arriving with the L1 response, then flush earlier in L1_WAIT
        mem_op(32'h80000004, 32'h20000401, 1'b0, 1'b1, 0, 0);
        push_retry(1);
        issue(1, 32'h00401234, 1'b0, 1'b0);
        wait_done("flush_same");

        mem_op(32'h80000004, 32'h20000401, 1'b0, 1'b1, 2, 0);
        push_retry(0);
        issue(0, 32'h00401234, 1'b0, 1'b0);
        wait_done("flush_early");

        // Stalled request handshake and slow memory
        mem_op(32'h80000004, 32'h20000401, 1'b0, 1'b0, 1, 3);
        mem_op(32'h80001004, 32'h048D14D7, 1'b0, 1'b0, 2, 2);
        push_ok(1, 32'h12345234, mk_ent(20'h00401, 20'h12345, 7'b1101110, 1'b0), -1);
        issue(1, 32'h00401234, 1'b0, 1'b0);
        wait_done("stall");

        // Bare mode
        satp_mode_i = 1'b0;
        push_ok(0, 32'hDEADB000, mk_ent(20'hDEADB, 20'hDEADB, 7'b1111111, 1'b0), 1);
        issue(0, 32'hDEADB000, 1'b0, 1'b1);
        wait_done("bare");

        // Reset in the middle of a walk; the late PTE must be ignored
        satp_mode_i = 1'b1;
        mem_op(32'h80000004, 32'h20000401, 1'b0, 1'b0, 4, 0);
        a0 = acc_cnt;
        issue(0, 32'h00401234, 1'b0, 1'b0);
        n = 0;
        while (acc_cnt == a0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("midrst_accepted", 64'(acc_cnt - a0), 64'd1);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_mem_valid", 64'(mem_req_valid_o), 64'd0);
        check("midrst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        wait_done("midrst");

        // Both ports held: grants alternate starting with port 0 after reset
        satp_mode_i = 1'b0;
        push_ok(0, 32'h11111000, mk_ent(20'h11111, 20'h11111, 7'b1111111, 1'b0), 1);
        push_ok(1, 32'h22222000, mk_ent(20'h22222, 20'h22222, 7'b1111111, 1'b0), 1);
        push_ok(0, 32'h11111000, mk_ent(20'h11111, 20'h11111, 7'b1111111, 1'b0), 1);
        push_ok(1, 32'h22222000, mk_ent(20'h22222, 20'h22222, 7'b1111111, 1'b0), 1);
        a0 = grant_cnt;
        @(posedge clk); #1;
        req_i[0] = '{vaddr: 32'h11111000, is_write: 1'b0, is_fetch: 1'b0};
        req_i[1] = '{vaddr: 32'h22222000, is_write: 1'b0, is_fetch: 1'b0};
        req_valid_i = 2'b11;
        n = 0;
        while (grant_cnt - a0 < 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("arb_grants", 64'(grant_cnt - a0), 64'd4);
        @(posedge clk); #1;
        req_valid_i = 2'b00;
        wait_done("arb");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
